inst_fetch_stage: RTL and testbench
===================================

Name: inst_fetch_stage

Overview:
- IF stage of the pipelined MIPS core; sits directly downstream of the byte-addressed instruction memory (32-bit read address in, 32-bit big-endian word out, registered on posedge clk, 1-cycle read latency, read only when its We=0).
- Owns the PC. Drives the memory read address, tracks which PC the returned word belongs to, and presents the IF/ID pipeline outputs to decode.
- Handles stall, flush and taken-branch redirect, and keeps imem_read_data stable under stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset and in IDLE
CNT_W, 16, width of fetch_count

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; 1 = program load finished, fetching allowed (loader owns memory We)
stall  in  1  hold IF/ID contents and PC
flush  in  1  squash IF/ID output (valid->0), no redirect
branch_taken  in  1  redirect PC to branch_target
branch_target  in  32  redirect byte address
imem_read_address  out  32  to instruction memory read_address (combinational)
imem_read_data  in  32  from instruction memory read_data
if_id_instr  out  32  instruction to decode; 32'h0 (NOP) when not valid
if_id_pc4  out  32  PC of if_id_instr plus 4
if_id_valid  out  1  if_id_instr is live
misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0
fetch_count  out  CNT_W  number of instructions accepted by decode

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc_q=RESET_PC, out_pc_q=RESET_PC, valid_q=0, misalign_err=0, fetch_count=0.
  - Resulting outputs: if_id_instr=0, if_id_pc4=RESET_PC+4, if_id_valid=0.
  - Reset mid-operation discards any in-flight word; no partial state survives.
- States: IDLE, RUN.
  - IDLE -> RUN on a clock edge with start=1.
  - RUN -> IDLE when start drops to 0; this also clears valid_q and sets pc_q=RESET_PC.
- Registers: pc_q is the next address to fetch. out_pc_q is the address whose word is currently in imem_read_data. valid_q is the IF/ID valid bit.
- Redirect address: tgt = {branch_target[31:2], 2'b00}. If branch_target[1:0] != 0 when branch_taken=1, misalign_err <= 1 and stays set until reset.
- imem_read_address (combinational), in priority order:
  - IDLE: RESET_PC.
  - RUN with branch_taken: tgt.
  - RUN with stall: out_pc_q. Re-reads the same word so imem_read_data holds.
  - Otherwise: pc_q.
- Per-edge update in RUN, in priority order:
  1. branch_taken: out_pc_q <= tgt, pc_q <= tgt+4, valid_q <= 1. The word in IF/ID this cycle is dropped; the target word appears next cycle.
  2. flush without branch: out_pc_q <= pc_q, pc_q <= pc_q+4, valid_q <= 0 for exactly that cycle's output; the following word is valid.
  3. stall: all registers hold.
  4. Normal: out_pc_q <= pc_q, pc_q <= pc_q+4, valid_q <= 1.
- Simultaneous events: branch_taken overrides both flush and stall. Flush overrides stall.
- First word: on the IDLE->RUN edge, memory samples RESET_PC. RUN cycle 1 shows word@RESET_PC with valid=1, pc_q=RESET_PC+4.
- Arithmetic: PC add is modulo 2^32 and wraps silently. The memory decodes only address[7:0]; no range checking here.
- Outputs:
  - if_id_instr = valid_q ? imem_read_data : 0.
  - if_id_pc4 = out_pc_q + 4.
  - if_id_valid = valid_q.
- fetch_count increments on every edge where if_id_valid=1 and stall=0 and flush=0 and branch_taken=0. It wraps at 2^CNT_W.

Test Plan:
- Sequential fetch: memory words @0..8 = 0x20080005, 0x20090003, 0x01095020. Assert rst_n, then start=1 -> consecutive cycles show those instrs with if_id_pc4 = 4, 8, 12, valid=1. fetch_count = 3 after the third.
- Stall hold: stall=1 for 3 cycles while 0x20090003 is shown -> instr and pc4=8 unchanged for all 3 cycles, imem_read_address=4. Release -> 0x01095020 next.
- Branch: branch_taken=1, target=0x40 (word 0xAC0A0000) in cycle k -> cycle k+1 shows 0xAC0A0000 with pc4=0x44. Repeat with stall=1 and flush=1 also high -> same result.
- Flush: flush=1 one cycle -> next output instr=0, valid=0, count unchanged. Cycle after shows the sequential successor with valid=1.
- Misaligned target 0x42 -> fetch from 0x40, misalign_err=1 sticky until rst_n low.
- Async reset mid-run and start drop: rst_n low between edges -> outputs 0 / pc4=RESET_PC+4 immediately. Separately, start=0 in RUN -> valid=0 and read address=RESET_PC next cycle.

Source files
------------

// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage
//   IF stage of the pipelined MIPS core. Owns the PC, drives the instruction
//   memory read address (the memory has one cycle of read latency), tracks
//   which PC the returned word belongs to, and presents the IF/ID outputs.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   start               level, 1 = program loaded, fetching allowed
//   stall               hold IF/ID contents and PC
//   flush               squash the next IF/ID output (valid -> 0)
//   branch_taken        redirect the PC to branch_target
//   branch_target       redirect byte address (bits [1:0] are dropped)
//   imem_read_address   combinational read address to instruction memory
//   imem_read_data      registered read data from instruction memory
//   if_id_instr         instruction to decode, 0 (NOP) when not valid
//   if_id_pc4           PC of if_id_instr plus 4
//   if_id_valid         if_id_instr is live
//   misalign_err        sticky: a redirect target was not word aligned
//   fetch_count         instructions accepted by decode (wraps)
//
// state | meaning
// IDLE  | program load in progress, read address parked at RESET_PC
// RUN   | fetching; pc_q is next address, out_pc_q is address of current word

module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_read_address,
    input  logic [31:0]      imem_read_data,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        out_pc_q, out_pc_d;
    logic               valid_q, valid_d;
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        tgt;
    logic               accept;

    assign tgt    = {branch_target[31:2], 2'b00};
    assign accept = valid_q && !stall && !flush && !branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            out_pc_q   <= RESET_PC;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_pc_q   <= out_pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        out_pc_d   = out_pc_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        count_d    = accept ? count_q + 1'b1 : count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Memory samples RESET_PC on this edge, so the first word
                    // is live in the first RUN cycle.
                    state_d  = RUN;
                    out_pc_d = RESET_PC;
                    pc_d     = RESET_PC + 32'd4;
                    valid_d  = 1'b1;
                end else begin
                    pc_d    = RESET_PC;
                    valid_d = 1'b0;
                end
            end
            RUN: begin
                if (!start) begin
                    state_d  = IDLE;
                    pc_d     = RESET_PC;
                    out_pc_d = RESET_PC;
                    valid_d  = 1'b0;
                end else if (branch_taken) begin
                    out_pc_d = tgt;
                    pc_d     = tgt + 32'd4;
                    valid_d  = 1'b1;
                    if (branch_target[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end else if (flush) begin
                    out_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    valid_d  = 1'b0;
                end else if (stall) begin
                    // hold everything
                end else begin
                    out_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_read_address = pc_q;
        if (state_q == IDLE) begin
            imem_read_address = RESET_PC;
        end else if (branch_taken) begin
            imem_read_address = tgt;
        end else if (stall) begin
            // Re-read the current word so imem_read_data stays put.
            imem_read_address = out_pc_q;
        end
    end

    assign if_id_instr  = valid_q ? imem_read_data : 32'h0;
    assign if_id_pc4    = out_pc_q + 32'd4;
    assign if_id_valid  = valid_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
module tb_inst_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stall, flush, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_read_address;
    logic [31:0] imem_read_data;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid, misalign_err;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .stall             (stall),
        .flush             (flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem_read_address (imem_read_address),
        .imem_read_data    (imem_read_data),
        .if_id_instr       (if_id_instr),
        .if_id_pc4         (if_id_pc4),
        .if_id_valid       (if_id_valid),
        .misalign_err      (misalign_err),
        .fetch_count       (fetch_count)
    );

    // Instruction memory: 64 words, decodes address[7:2], registered read.
    logic [31:0] mem [0:63];
    always @(posedge clk) imem_read_data <= mem[imem_read_address[7:2]];

    typedef struct {
        logic        start, stall, flush, br;
        logic [31:0] tgt;
        logic [31:0] addr;      // expected read address during this cycle
        logic [31:0] instr;     // expected outputs after the edge
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] count;
        logic        mis;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[21];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        start = v.start; stall = v.stall; flush = v.flush;
        branch_taken = v.br; branch_target = v.tgt;
        #1;
        chk32($sformatf("addr[%0d]", idx), imem_read_address, v.addr);
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk32($sformatf("instr[%0d]", idx), if_id_instr, e.instr);
        chk32($sformatf("pc4[%0d]", idx),   if_id_pc4,   e.pc4);
        chk32($sformatf("valid[%0d]", idx), {31'b0, if_id_valid}, {31'b0, e.valid});
        chk32($sformatf("count[%0d]", idx), {16'b0, fetch_count}, {16'b0, e.count});
        chk32($sformatf("mis[%0d]", idx),   {31'b0, misalign_err}, {31'b0, e.mis});
    endtask

    function automatic vec_t mk(input logic s, st, fl, br, input logic [31:0] tgt, addr,
                                input logic [31:0] instr, pc4, input logic valid,
                                input logic [15:0] count, input logic mis);
        vec_t v;
        v.start = s; v.stall = st; v.flush = fl; v.br = br; v.tgt = tgt; v.addr = addr;
        v.instr = instr; v.pc4 = pc4; v.valid = valid; v.count = count; v.mis = mis;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (i * 4);
        mem[0]  = 32'h2008_0005;
        mem[1]  = 32'h2009_0003;
        mem[2]  = 32'h0109_5020;
        mem[3]  = 32'h3C0B_1234;
        mem[16] = 32'hAC0A_0000;
        mem[17] = 32'h8C0B_0004;

        //            st st fl br tgt    addr   instr          pc4    v  cnt mis
        vecs[0]  = mk(1, 0, 0, 0, 32'h0, 32'h00, 32'h2008_0005, 32'h04, 1, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h0, 32'h04, 32'h2009_0003, 32'h08, 1, 1, 0);
        vecs[2]  = mk(1, 1, 0, 0, 32'h0, 32'h04, 32'h2009_0003, 32'h08, 1, 1, 0);
        vecs[3]  = mk(1, 1, 0, 0, 32'h0, 32'h04, 32'h2009_0003, 32'h08, 1, 1, 0);
        vecs[4]  = mk(1, 1, 0, 0, 32'h0, 32'h04, 32'h2009_0003, 32'h08, 1, 1, 0);
        vecs[5]  = mk(1, 0, 0, 0, 32'h0, 32'h08, 32'h0109_5020, 32'h0C, 1, 2, 0);
        vecs[6]  = mk(1, 0, 0, 0, 32'h0, 32'h0C, 32'h3C0B_1234, 32'h10, 1, 3, 0);
        vecs[7]  = mk(1, 0, 0, 1, 32'h40, 32'h40, 32'hAC0A_0000, 32'h44, 1, 3, 0);
        vecs[8]  = mk(1, 0, 0, 0, 32'h0, 32'h44, 32'h8C0B_0004, 32'h48, 1, 4, 0);
        vecs[9]  = mk(1, 1, 1, 1, 32'h40, 32'h40, 32'hAC0A_0000, 32'h44, 1, 4, 0);
        vecs[10] = mk(1, 0, 1, 0, 32'h0, 32'h44, 32'h0,         32'h48, 0, 4, 0);
        vecs[11] = mk(1, 0, 0, 0, 32'h0, 32'h48, 32'hA000_0048, 32'h4C, 1, 4, 0);
        vecs[12] = mk(1, 0, 0, 0, 32'h0, 32'h4C, 32'hA000_004C, 32'h50, 1, 5, 0);
        vecs[13] = mk(1, 1, 1, 0, 32'h0, 32'h4C, 32'h0,         32'h54, 0, 5, 0);
        vecs[14] = mk(1, 0, 0, 0, 32'h0, 32'h54, 32'hA000_0054, 32'h58, 1, 5, 0);
        vecs[15] = mk(1, 0, 0, 1, 32'h42, 32'h40, 32'hAC0A_0000, 32'h44, 1, 5, 1);
        vecs[16] = mk(1, 0, 0, 0, 32'h0, 32'h44, 32'h8C0B_0004, 32'h48, 1, 6, 1);
        vecs[17] = mk(0, 0, 0, 0, 32'h0, 32'h48, 32'h0,         32'h04, 0, 7, 1);
        vecs[18] = mk(0, 0, 0, 0, 32'h0, 32'h00, 32'h0,         32'h04, 0, 7, 1);
        vecs[19] = mk(1, 0, 0, 0, 32'h0, 32'h00, 32'h2008_0005, 32'h04, 1, 7, 1);
        vecs[20] = mk(1, 0, 0, 0, 32'h0, 32'h04, 32'h2009_0003, 32'h08, 1, 8, 1);

        rst_n = 1'b0; start = 0; stall = 0; flush = 0; branch_taken = 0; branch_target = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk32("rst_instr", if_id_instr, 32'h0);
        chk32("rst_pc4",   if_id_pc4,   32'h4);
        chk32("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk32("rst_count", {16'b0, fetch_count}, 32'h0);
        chk32("rst_mis",   {31'b0, misalign_err}, 32'h0);
        chk32("rst_addr",  imem_read_address, 32'h0);

        for (int i = 0; i < 21; i++) apply(vecs[i], i);

        // Async reset between edges: outputs must clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        chk32("arst_instr", if_id_instr, 32'h0);
        chk32("arst_pc4",   if_id_pc4,   32'h4);
        chk32("arst_valid", {31'b0, if_id_valid}, 32'h0);
        chk32("arst_count", {16'b0, fetch_count}, 32'h0);
        chk32("arst_mis",   {31'b0, misalign_err}, 32'h0);
        chk32("arst_addr",  imem_read_address, 32'h0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Restart, then redirect to the top of the address space: PC wraps.
        apply(mk(1, 0, 0, 0, 32'h0, 32'h00, 32'h2008_0005, 32'h04, 1, 0, 0), 100);
        apply(mk(1, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hA000_00FC, 32'h00, 1, 0, 0), 101);
        apply(mk(1, 0, 0, 0, 32'h0, 32'h00, 32'h2008_0005, 32'h04, 1, 1, 0), 102);
        apply(mk(1, 0, 0, 0, 32'h0, 32'h04, 32'h2009_0003, 32'h08, 1, 2, 0), 103);

        chk32("sb_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
